// File: rtl/sprite_video_gen.sv
`default_nettype none
// ============================================================================
// Module      : sprite_video_gen
// Description : Streams RGB888 video frames over AXI4-Stream. Each pixel is
//               the background colour overlaid with up to NUM_SPRITES solid
//               rectangles; the lowest-index hitting sprite wins. Sprite and
//               background settings are captured once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_video_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int NUM_SPRITES = 4,
    parameter int SIZE_W      = 8,
    localparam int XW         = $clog2(H_VISIBLE),
    localparam int YW         = $clog2(V_VISIBLE)
) (
    input  logic                      pixel_clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [11:0]               bg_color,
    input  logic [NUM_SPRITES-1:0]    sprite_en,
    input  logic [NUM_SPRITES*XW-1:0] sprite_x,
    input  logic [NUM_SPRITES*YW-1:0] sprite_y,
    input  logic [NUM_SPRITES*SIZE_W-1:0] sprite_w,
    input  logic [NUM_SPRITES*SIZE_W-1:0] sprite_h,
    input  logic [NUM_SPRITES*12-1:0] sprite_color,
    output logic [23:0]               tdata,
    output logic                      tvalid,
    output logic                      tuser,
    output logic                      tlast,
    input  logic                      tready,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);

    // Sums of position + size need one bit beyond the wider operand so a
    // sprite hanging off the screen edge is clipped rather than wrapped.
    localparam int c_XSUM_W = ((XW > SIZE_W) ? XW : SIZE_W) + 1;
    localparam int c_YSUM_W = ((YW > SIZE_W) ? YW : SIZE_W) + 1;
    localparam logic [XW-1:0] c_X_MAX = XW'(H_VISIBLE - 1);
    localparam logic [YW-1:0] c_Y_MAX = YW'(V_VISIBLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Per-frame shadow copy of the sprite/background configuration
    logic [11:0]                   r_bg;
    logic [NUM_SPRITES-1:0]        r_en;
    logic [NUM_SPRITES*XW-1:0]     r_sx;
    logic [NUM_SPRITES*YW-1:0]     r_sy;
    logic [NUM_SPRITES*SIZE_W-1:0] r_sw;
    logic [NUM_SPRITES*SIZE_W-1:0] r_sh;
    logic [NUM_SPRITES*12-1:0]     r_col;

    // Coordinates of the pixel currently held in the output register
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    logic [23:0]   r_tdata;
    logic          r_tuser;
    logic          r_tlast;
    logic          r_frame_done;
    logic [15:0]   r_frame_count;

    logic          w_hs;
    logic          w_frame_end;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;

    // Configuration feeding the pixel evaluator: live inputs during LOAD
    // (the shadow registers are being written that same cycle), else shadow.
    logic                          w_use_live;
    logic [11:0]                   w_src_bg;
    logic [NUM_SPRITES-1:0]        w_src_en;
    logic [NUM_SPRITES*XW-1:0]     w_src_x;
    logic [NUM_SPRITES*YW-1:0]     w_src_y;
    logic [NUM_SPRITES*SIZE_W-1:0] w_src_w;
    logic [NUM_SPRITES*SIZE_W-1:0] w_src_h;
    logic [NUM_SPRITES*12-1:0]     w_src_col;

    logic [NUM_SPRITES-1:0]        w_hit;
    logic [11:0]                   w_color;
    logic [23:0]                   w_pixel;

    assign tvalid      = (r_state == S_STREAM);
    assign tdata       = r_tdata;
    assign tuser       = r_tuser;
    assign tlast       = r_tlast;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

    assign w_hs        = tvalid && tready;
    assign w_frame_end = w_hs && (r_x == c_X_MAX) && (r_y == c_Y_MAX);

    assign w_use_live = (r_state == S_LOAD);
    assign w_src_bg   = w_use_live ? bg_color     : r_bg;
    assign w_src_en   = w_use_live ? sprite_en    : r_en;
    assign w_src_x    = w_use_live ? sprite_x     : r_sx;
    assign w_src_y    = w_use_live ? sprite_y     : r_sy;
    assign w_src_w    = w_use_live ? sprite_w     : r_sw;
    assign w_src_h    = w_use_live ? sprite_h     : r_sh;
    assign w_src_col  = w_use_live ? sprite_color : r_col;

    // State register
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; enable is only consulted between frames
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_STREAM;
            S_STREAM: if (w_frame_end) w_state_next = enable ? S_LOAD : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Coordinates of the pixel the output register loads this cycle
    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        if (r_state == S_LOAD) begin
            w_nx = '0;
            w_ny = '0;
        end else if (w_hs) begin
            if (r_x != c_X_MAX) begin
                w_nx = r_x + 1'b1;
            end else begin
                w_nx = '0;
                w_ny = (r_y != c_Y_MAX) ? (r_y + 1'b1) : '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
            logic [c_XSUM_W-1:0] w_px, w_x0, w_x1;
            logic [c_YSUM_W-1:0] w_py, w_y0, w_y1;
            assign w_px = c_XSUM_W'(w_nx);
            assign w_py = c_YSUM_W'(w_ny);
            assign w_x0 = c_XSUM_W'(w_src_x[gi*XW +: XW]);
            assign w_y0 = c_YSUM_W'(w_src_y[gi*YW +: YW]);
            assign w_x1 = w_x0 + c_XSUM_W'(w_src_w[gi*SIZE_W +: SIZE_W]);
            assign w_y1 = w_y0 + c_YSUM_W'(w_src_h[gi*SIZE_W +: SIZE_W]);
            assign w_hit[gi] = w_src_en[gi] && (w_px >= w_x0) && (w_px < w_x1)
                               && (w_py >= w_y0) && (w_py < w_y1);
        end
    endgenerate

    // Colour priority: scanning from the top index down lets index 0 win
    always_comb begin
        w_color = w_src_bg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) w_color = w_src_col[i*12 +: 12];
        end
    end

    assign w_pixel = {w_color[11:8], w_color[11:8],
                      w_color[7:4],  w_color[7:4],
                      w_color[3:0],  w_color[3:0]};

    // Shadow capture, pixel counters, output register and frame bookkeeping
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_bg          <= '0;
            r_en          <= '0;
            r_sx          <= '0;
            r_sy          <= '0;
            r_sw          <= '0;
            r_sh          <= '0;
            r_col         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_tdata       <= '0;
            r_tuser       <= 1'b0;
            r_tlast       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == S_LOAD) begin
                r_bg  <= bg_color;
                r_en  <= sprite_en;
                r_sx  <= sprite_x;
                r_sy  <= sprite_y;
                r_sw  <= sprite_w;
                r_sh  <= sprite_h;
                r_col <= sprite_color;
            end
            if (w_frame_end) begin
                r_x           <= '0;
                r_y           <= '0;
                r_tuser       <= 1'b0;
                r_tlast       <= 1'b0;
                r_frame_done  <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
            end else if ((r_state == S_LOAD) || w_hs) begin
                r_x     <= w_nx;
                r_y     <= w_ny;
                r_tdata <= w_pixel;
                r_tuser <= (w_nx == '0) && (w_ny == '0);
                r_tlast <= (w_nx == c_X_MAX);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_video_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_video_gen
// Description : Directed scoreboard bench for sprite_video_gen on a reduced
//               20x12 raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_video_gen;

    localparam int H  = 20;
    localparam int V  = 12;
    localparam int NS = 4;
    localparam int SW = 8;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    logic                pixel_clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [11:0]         bg_color;
    logic [NS-1:0]       sprite_en;
    logic [NS*XW-1:0]    sprite_x;
    logic [NS*YW-1:0]    sprite_y;
    logic [NS*SW-1:0]    sprite_w;
    logic [NS*SW-1:0]    sprite_h;
    logic [NS*12-1:0]    sprite_color;
    logic [23:0]         tdata;
    logic                tvalid;
    logic                tuser;
    logic                tlast;
    logic                tready;
    logic                frame_done;
    logic [15:0]         frame_count;

    sprite_video_gen #(
        .H_VISIBLE   (H),
        .V_VISIBLE   (V),
        .NUM_SPRITES (NS),
        .SIZE_W      (SW)
    ) dut (
        .pixel_clk    (pixel_clk),
        .reset        (reset),
        .enable       (enable),
        .bg_color     (bg_color),
        .sprite_en    (sprite_en),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_w     (sprite_w),
        .sprite_h     (sprite_h),
        .sprite_color (sprite_color),
        .tdata        (tdata),
        .tvalid       (tvalid),
        .tuser        (tuser),
        .tlast        (tlast),
        .tready       (tready),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks   = 0;
    int failures = 0;

    int cfg_en [NS];
    int cfg_sx [NS];
    int cfg_sy [NS];
    int cfg_sw [NS];
    int cfg_sh [NS];
    int cfg_col[NS];
    int cfg_bg;

    logic [25:0] sb[$];
    logic [23:0] cap_mem [0:H*V-1];
    int hs_total, last_count, user_count, fd_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_px(input int x, input int y);
        int c;
        c = cfg_bg;
        for (int i = 0; i < NS; i++) begin
            if (cfg_en[i] != 0 && x >= cfg_sx[i] && x < cfg_sx[i] + cfg_sw[i]
                && y >= cfg_sy[i] && y < cfg_sy[i] + cfg_sh[i]) begin
                c = cfg_col[i];
                break;
            end
        end
        return {8'(((c >> 8) & 15) * 17), 8'(((c >> 4) & 15) * 17), 8'((c & 15) * 17)};
    endfunction

    task automatic push_frame();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                sb.push_back({model_px(x, y), (x == 0 && y == 0), (x == H - 1)});
            end
        end
    endtask

    task automatic apply_cfg();
        bg_color = 12'(cfg_bg);
        for (int i = 0; i < NS; i++) begin
            sprite_en[i]              = (cfg_en[i] != 0);
            sprite_x[i*XW +: XW]      = XW'(cfg_sx[i]);
            sprite_y[i*YW +: YW]      = YW'(cfg_sy[i]);
            sprite_w[i*SW +: SW]      = SW'(cfg_sw[i]);
            sprite_h[i*SW +: SW]      = SW'(cfg_sh[i]);
            sprite_color[i*12 +: 12]  = 12'(cfg_col[i]);
        end
    endtask

    task automatic set_sprite(input int i, input int en, input int sx, input int sy,
                              input int sw, input int sh, input int col);
        cfg_en[i] = en; cfg_sx[i] = sx; cfg_sy[i] = sy;
        cfg_sw[i] = sw; cfg_sh[i] = sh; cfg_col[i] = col;
    endtask

    task automatic clear_stats();
        hs_total = 0; last_count = 0; user_count = 0; fd_seen = 0;
    endtask

    // Consume n beats; tready is chosen first each cycle so the handshake
    // decision matches what the DUT sees on the next rising edge.
    task automatic run_beats(input int n, input int stall_pct, input int drop_en_at, input int cfg_at);
        int          got;
        int          cyc;
        logic [25:0] obs;
        logic [25:0] prev;
        logic [25:0] exp;
        logic        prev_stall;
        got = 0; cyc = 0; prev = '0; prev_stall = 1'b0;
        while (got < n && cyc < 8 * n + 100) begin
            @(negedge pixel_clk);
            cyc++;
            obs = {tdata, tuser, tlast};
            if (frame_done) fd_seen++;
            if (prev_stall) check("stall_hold", 32'(obs), 32'(prev));
            tready = ($urandom_range(0, 99) >= stall_pct);
            if (tvalid && tready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_extra_beat observed=0x%0h expected=none", obs);
                end
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("beat", 32'(obs), 32'(exp));
                end
                cap_mem[hs_total % (H * V)] = tdata;
                hs_total++;
                if (tlast) last_count++;
                if (tuser) user_count++;
                got++;
                if (got == drop_en_at) enable = 1'b0;
                if (got == cfg_at) apply_cfg();
            end
            prev_stall = tvalid && !tready;
            prev       = obs;
        end
        check("beats_done", 32'(got), 32'(n));
    endtask

    task automatic post_frame(input int k);
        repeat (k) begin
            @(negedge pixel_clk);
            tready = 1'b0;
            if (frame_done) fd_seen++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; tready = 1'b0;
        for (int i = 0; i < NS; i++) set_sprite(i, 0, 0, 0, 0, 0, 0);
        cfg_bg = 'h000;
        apply_cfg();

        // Reset state
        repeat (3) @(negedge pixel_clk);
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_tdata", 32'(tdata), 0);
        check("rst_tuser_tlast", 32'({tuser, tlast}), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_count", 32'(frame_count), 0);

        // Background-only frame, leaving reset with enable high
        cfg_bg = 'h00F;
        apply_cfg();
        clear_stats();
        push_frame();
        enable = 1'b1;
        @(negedge pixel_clk);
        reset = 1'b0;
        @(negedge pixel_clk);
        check("load_tvalid", 32'(tvalid), 0);
        @(negedge pixel_clk);
        check("stream_tvalid", 32'(tvalid), 1);
        check("first_tdata", 32'(tdata), 32'h0000FF);
        check("first_tuser", 32'(tuser), 1);
        run_beats(H * V, 0, 1, -1);
        post_frame(3);
        check("A_lines", 32'(last_count), V);
        check("A_tuser_cnt", 32'(user_count), 1);
        check("A_frame_done", 32'(fd_seen), 1);
        check("A_frame_count", 32'(frame_count), 1);
        check("A_idle", 32'(tvalid), 0);
        check("A_last_px", 32'(cap_mem[H*V-1]), 32'h0000FF);

        // Sprites: overlap priority, edge clipping, zero width, random stalls
        cfg_bg = 'h123;
        set_sprite(0, 1, 3, 2, 5, 4, 'hF00);
        set_sprite(1, 1, 1, 1, 6, 6, 'h0F0);
        set_sprite(2, 1, 15, 5, 20, 3, 'hABC);
        set_sprite(3, 1, 8, 8, 0, 4, 'hFFF);
        apply_cfg();
        clear_stats();
        push_frame();
        enable = 1'b1;
        run_beats(H * V, 30, 1, -1);
        post_frame(3);
        check("B_overlap", 32'(cap_mem[2*H+3]), 32'hFF0000);
        check("B_sprite1", 32'(cap_mem[1*H+2]), 32'h00FF00);
        check("B_clip_edge", 32'(cap_mem[6*H+19]), 32'hAABBCC);
        check("B_zero_w", 32'(cap_mem[8*H+8]), 32'h112233);
        check("B_bg", 32'(cap_mem[0]), 32'h112233);
        check("B_lines", 32'(last_count), V);
        check("B_frame_count", 32'(frame_count), 2);

        // Mid-frame sprite move applies from the next frame onward
        clear_stats();
        push_frame();
        cfg_sx[0] = 10;
        push_frame();
        enable = 1'b1;
        run_beats(2 * H * V, 30, H * V + 2, 10);
        post_frame(3);
        check("C_moved", 32'(cap_mem[2*H+10]), 32'hFF0000);
        check("C_old_pos", 32'(cap_mem[2*H+3]), 32'h00FF00);
        check("C_tuser_cnt", 32'(user_count), 2);
        check("C_frame_done", 32'(fd_seen), 2);
        check("C_frame_count", 32'(frame_count), 4);

        // Reset while pixel (5,3) is presented
        clear_stats();
        push_frame();
        enable = 1'b1;
        run_beats(3 * H + 5, 0, -1, -1);
        @(negedge pixel_clk);
        check("D_px_5_3", 32'({tdata, tuser, tlast}), 32'({model_px(5, 3), 1'b0, 1'b0}));
        check("D_count_before", 32'(frame_count), 4);
        tready = 1'b0;
        reset  = 1'b1;
        @(negedge pixel_clk);
        check("D_rst_tvalid", 32'(tvalid), 0);
        check("D_rst_count", 32'(frame_count), 0);
        check("D_rst_tdata", 32'(tdata), 0);
        check("D_rst_done", 32'(frame_done), 0);
        sb.delete();
        clear_stats();
        push_frame();
        reset = 1'b0;
        run_beats(H * V, 30, 1, -1);
        post_frame(3);
        check("D_tuser_cnt", 32'(user_count), 1);
        check("D_frame_done", 32'(fd_seen), 1);
        check("D_frame_count", 32'(frame_count), 1);
        check("D_sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_video_gen.md
SPRITE_VIDEO_GEN -- requirements
Module: sprite_video_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-003 Parameter NUM_SPRITES, default 4, number of rectangle sprites.
REQ-004 Parameter SIZE_W, default 8, width of sprite width/height fields.
REQ-005 Derived XW = $clog2(H_VISIBLE), YW = $clog2(V_VISIBLE); not overridable.
REQ-006 pixel_clk  in  1  pixel clock; the only clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  level; when high, frames are streamed back to back.
REQ-009 bg_color  in  12  background colour, RGB444.
REQ-010 sprite_en  in  NUM_SPRITES  per-sprite enable.
REQ-011 sprite_x / sprite_y  in  NUM_SPRITES*XW / NUM_SPRITES*YW  packed top-left corners, sprite i at bits [i*XW +: XW] (same packing for y).
REQ-012 sprite_w / sprite_h  in  NUM_SPRITES*SIZE_W each  packed sprite sizes.
REQ-013 sprite_color  in  NUM_SPRITES*12  packed RGB444 sprite colours.
REQ-014 tdata  out  24  {R8,G8,B8} pixel.
REQ-015 tvalid / tuser / tlast  out  1 each  AXI4-Stream video valid, start-of-frame, end-of-line.
REQ-016 tready  in  1  downstream ready.
REQ-017 frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-018 frame_count  out  16  number of completed frames; wraps 0xFFFF -> 0.

Function
REQ-019 FSM states: IDLE, LOAD, STREAM.
REQ-020 IDLE: tvalid=0; go to LOAD when enable=1.
REQ-021 LOAD, exactly one cycle: latch all sprite_* and bg_color into shadow registers; set x=0, y=0; register pixel (0,0) into the output; go to STREAM.
REQ-022 Sprite/background inputs are sampled only in LOAD; changes mid-frame do not affect the current frame.
REQ-023 STREAM: tvalid=1; output registers hold the pixel at counters (x,y).
REQ-024 Handshake = tvalid && tready; tdata/tuser/tlast are stable while tvalid=1 and tready=0.
REQ-025 On handshake with x < H_VISIBLE-1: x increments and the output register loads pixel (x+1,y) in the same cycle; no bubbles occur while tready=1.
REQ-026 On handshake with x = H_VISIBLE-1 and y < V_VISIBLE-1: x <= 0, y increments.
REQ-027 On handshake at (H_VISIBLE-1, V_VISIBLE-1): frame_done pulses next cycle; frame_count increments; go to LOAD if enable=1, else IDLE with tvalid=0.
REQ-028 enable deasserted mid-frame takes effect only at the frame end; the frame always completes.
REQ-029 tuser=1 only while the output holds (0,0); tlast=1 only while x = H_VISIBLE-1.
REQ-030 Pixel hit for sprite i: sprite_en[i] && x >= sx && x < sx+sw && y >= sy && y < sy+sh; sums are computed at full width (XW+1 / YW+1 bits, or wider if SIZE_W requires) with no wrap.
REQ-031 A sprite with w=0 or h=0 never hits; a sprite extending past the screen edge is clipped.
REQ-032 Overlap: the lowest-index hitting sprite wins; with no hit, bg_color is used.
REQ-033 RGB444 -> RGB888 by nibble replication: R8={R4,R4}, and likewise for G and B.

Reset
REQ-034 While reset=1 on a pixel_clk edge: state=IDLE; tvalid, tuser, tlast, frame_done = 0; tdata=0; frame_count=0; x=y=0; shadow registers = 0.
REQ-035 Reset mid-frame abandons the frame; there is no frame_done pulse and frame_count does not increment.
REQ-036 Leaving reset with enable=1: LOAD on the first cycle and tvalid=1 on the second.

Verification
REQ-037 Defaults; enable=1; tready=1; sprites disabled; bg_color=0x00F -> 307200 beats of tdata=0x0000FF; tuser on beat 0 only; tlast every 640th beat; one frame_done; frame_count=1.
REQ-038 Sprite0 at (100,50), size 20x40, colour 0x0FF -> tdata=0x00FFFF exactly for x in 100..119 and y in 50..89; all other beats are background.
REQ-039 Sprite0 and sprite1 both covering (10,10), colours 0xF00 and 0x0F0 -> pixel (10,10) is 0xFF0000; sprite at x=630 with w=20 -> clipped at x=639, and the line still has 640 beats.
REQ-040 Random tready with 30% stall rate -> no lost or duplicated pixels; tdata/tuser/tlast are stable during stalls; the sequence matches the stall-free run.
REQ-041 Change sprite0_x mid-frame -> the current frame is unchanged and the new position appears from the next tuser onward.
REQ-042 reset asserted at pixel (5,3) -> next cycle tvalid=0, frame_count=0; a full frame restarts at (0,0) with tuser.
